// File: rtl/mult4_seq_ctrl.sv
// Purpose : sequential shift-and-add unsigned WIDTH x WIDTH multiplier with valid/ready on both sides.
// Latency : WIDTH cycles from operand acceptance to out_valid; one operation per WIDTH+2 cycles.
// Backpr. : product and out_valid hold indefinitely while out_ready=0; in_ready stays low until the result drains.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset (0 = reset)
//   in_valid   operand source presents A/B
//   in_ready   block is idle and will take A/B on this edge
//   A, B       unsigned multiplicand / multiplier (WIDTH bits)
//   out_valid  product is available
//   out_ready  consumer takes the product on this edge
//   product    unsigned A*B (2*WIDTH bits), held after hand-off
//   busy       high while iterating
module mult4_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   // Counter only has to reach WIDTH-1; $clog2 is at least 1 for WIDTH >= 2.
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;

   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   mcand_nxt;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     mplier_nxt;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_nxt;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        cnt_nxt;
   logic [2*WIDTH-1:0]   product_q;
   logic [2*WIDTH-1:0]   product_nxt;

   // Partial product for the current multiplier bit. The running sum is
   // bounded by (2^WIDTH-1)^2, so the 2*WIDTH-bit add never carries out.
   logic [2*WIDTH-1:0]   add_term;
   logic [2*WIDTH-1:0]   acc_sum;

   assign add_term = mplier[0] ? mcand : '0;
   assign acc_sum  = acc + add_term;

   // State register and datapath registers. Reset wins over every input,
   // so an in-flight operation is dropped without ever raising out_valid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         product_q <= '0;
      end else begin
         state     <= state_nxt;
         mcand     <= mcand_nxt;
         mplier    <= mplier_nxt;
         acc       <= acc_nxt;
         cnt       <= cnt_nxt;
         product_q <= product_nxt;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_nxt   = state;
      mcand_nxt   = mcand;
      mplier_nxt  = mplier;
      acc_nxt     = acc;
      cnt_nxt     = cnt;
      product_nxt = product_q;

      case (state)
         IDLE: begin
            // in_ready is implied by IDLE, so in_valid alone completes the handshake.
            if (in_valid) begin
               mcand_nxt  = {{WIDTH{1'b0}}, A};
               mplier_nxt = B;
               acc_nxt    = '0;
               cnt_nxt    = '0;
               state_nxt  = CALC;
            end
         end

         CALC: begin
            // Fixed WIDTH iterations; no early exit when the multiplier empties,
            // so latency does not depend on operand values.
            acc_nxt    = acc_sum;
            mcand_nxt  = mcand << 1;
            mplier_nxt = mplier >> 1;
            cnt_nxt    = cnt + CW'(1);
            if (cnt == LAST) begin
               product_nxt = acc_sum;
               state_nxt   = DONE;
            end
         end

         DONE: begin
            // out_valid is implied by DONE; product_q is untouched until the
            // next operation completes, so it is stable under backpressure
            // and keeps its value after the hand-off.
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // All handshake/status outputs decode from state only: no combinational
   // path from in_valid or out_ready to any output.
   assign in_ready  = (state == IDLE);
   assign busy      = (state == CALC);
   assign out_valid = (state == DONE);
   assign product   = product_q;

endmodule

// File: doc/mult4_seq_ctrl.md
Name: mult4_seq_ctrl

Overview:
Sequential shift-and-add controller for unsigned WIDTH x WIDTH multiplication. It is the time-multiplexed counterpart to the combinational 4-bit multiplier, for use where area matters more than latency.
Operands are accepted over a valid/ready handshake. The block iterates one multiplier bit per clock and presents a 2*WIDTH product over a second valid/ready handshake.
It sits between an operand source (test sequencer or CPU-side register block) and a result consumer.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  synchronous, active-low reset; sampled on rising clk; 0 = reset.
in_valid  input  1  operand source has A/B valid.
in_ready  output  1  block can accept operands.
A  input  WIDTH  unsigned multiplicand.
B  input  WIDTH  unsigned multiplier.
out_valid  output  1  product valid.
out_ready  input  1  consumer accepts product.
product  output  2*WIDTH  unsigned A*B.
busy  output  1  high while in CALC.

Behaviour:
- Reset: synchronous, active-low. On any rising clk with reset==0:
  - state<=IDLE; in_ready=1; out_valid=0; busy=0; product=0.
  - Internal regs (mcand, mplier, acc, cnt) are cleared.
  - Reset overrides every other input, including mid-CALC and mid-DONE. Any in-flight operation is discarded with no out_valid pulse.
- FSM states: IDLE, CALC, DONE. All outputs are registered or decoded from state only; no combinational path from in_valid/out_ready to any output.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On an edge with in_valid&&in_ready: mcand<={WIDTH'0,A}, mplier<=B, acc<=0, cnt<=0, go to CALC.
  - A/B are sampled only on this edge; later changes to A/B are ignored.
- CALC:
  - in_ready=0, busy=1.
  - Each edge: if mplier[0], acc<=acc+mcand (2*WIDTH-bit add, cannot overflow); mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1, after the final update: product<=final acc value, go to DONE.
  - No early exit when mplier reaches 0; latency is fixed.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - product holds stable while out_valid=1 and out_ready=0 (backpressure, unlimited duration).
  - On an edge with out_valid&&out_ready: go to IDLE; out_valid drops the next cycle; product keeps its last value.
- Latency: acceptance edge T0; out_valid first high in the cycle after edge T0+WIDTH (WIDTH=4: out_valid high 4 cycles after acceptance).
- Throughput: one operation per WIDTH+2 cycles with out_ready tied high. The earliest next acceptance is the edge after the DONE->IDLE edge.
- Simultaneous events:
  - in_valid asserted during CALC or DONE is ignored; the source must hold it until in_ready.
  - out_ready with out_valid=0 has no effect.
- Edge values:
  - A=0 or B=0 gives product=0.
  - The maximum product (2^WIDTH-1)^2 is exact, e.g. 225 for WIDTH=4.
- No X on outputs after the first reset edge.

Test Plan:
- Reset then A=7, B=6, in_valid pulse, out_ready=1 -> out_valid high 4 cycles after acceptance, product=8'd42 (0x2A); busy high exactly 4 cycles.
- A=15, B=15 -> product=8'd225; A=0, B=2 -> product=0; A=5, B=14 -> product=8'd70.
- out_ready held 0 for 10 cycles after out_valid -> product and out_valid stable all 10 cycles, in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1.
- Change A/B and pulse in_valid during CALC (A=4, B=10 in flight; A=5, B=12 injected) -> first result 40; second pair is accepted only when in_ready returns and yields 60.
- Assert reset=0 for one cycle mid-CALC -> next cycle state IDLE, out_valid=0, busy=0, product=0, no result emitted; a subsequent A=2, B=10 yields 20.
- Back-to-back stream of 11 pairs with in_valid held high and out_ready=1 -> one result every 6 cycles, each matching A*B.
